// File: rtl/id_ex_stage_if.sv
// ID->EX boundary bundle: decode fields, register data, result bypasses and flush in;
// stall, registered EX bundle and bubble statistics out.
interface id_ex_stage_if #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              IdValid;
  logic [4:0]        IdRsAddr;
  logic [4:0]        IdRtAddr;
  logic [4:0]        IdRdAddr;
  logic [31:0]       IdImm;
  logic [CTRL_W-1:0] IdCtrl;
  logic              IdMemRead;
  logic              IdRegWrite;
  logic [31:0]       RegARdData;
  logic [31:0]       RegBRdData;
  logic [4:0]        ExMemWrAddr;
  logic [31:0]       ExMemWrData;
  logic              ExMemRegWrite;
  logic [4:0]        MemWbWrAddr;
  logic [31:0]       MemWbWrData;
  logic              MemWbRegWrite;
  logic              Flush;
  logic              Stall;
  logic              ExValid;
  logic [31:0]       ExRsData;
  logic [31:0]       ExRtData;
  logic [4:0]        ExRtAddr;
  logic [4:0]        ExRdAddr;
  logic [31:0]       ExImm;
  logic [CTRL_W-1:0] ExCtrl;
  logic              ExMemRead;
  logic              ExRegWrite;
  logic [CNT_W-1:0]  BubbleCount;

  modport master (
    output IdValid, IdRsAddr, IdRtAddr, IdRdAddr, IdImm, IdCtrl, IdMemRead, IdRegWrite,
           RegARdData, RegBRdData, ExMemWrAddr, ExMemWrData, ExMemRegWrite,
           MemWbWrAddr, MemWbWrData, MemWbRegWrite, Flush,
    input  Stall, ExValid, ExRsData, ExRtData, ExRtAddr, ExRdAddr, ExImm, ExCtrl,
           ExMemRead, ExRegWrite, BubbleCount
  );

  modport slave (
    input  IdValid, IdRsAddr, IdRtAddr, IdRdAddr, IdImm, IdCtrl, IdMemRead, IdRegWrite,
           RegARdData, RegBRdData, ExMemWrAddr, ExMemWrData, ExMemRegWrite,
           MemWbWrAddr, MemWbWrData, MemWbRegWrite, Flush,
    output Stall, ExValid, ExRsData, ExRtData, ExRtAddr, ExRdAddr, ExImm, ExCtrl,
           ExMemRead, ExRegWrite, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass muxes, load-use stall detection
// (one bubble per load) and a saturating bubble counter.
module id_ex_stage #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            r_state;
  logic              r_ex_valid;
  logic [31:0]       r_ex_rs_data;
  logic [31:0]       r_ex_rt_data;
  logic [4:0]        r_ex_rt_addr;
  logic [4:0]        r_ex_rd_addr;
  logic [31:0]       r_ex_imm;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_ex_mem_read;
  logic              r_ex_reg_write;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [31:0]       w_op_a;
  logic [31:0]       w_op_b;
  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;

  // Register 0 reads as zero; the younger EX/MEM result beats MEM/WB.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic        exm_we,
    input logic [4:0]  exm_addr,
    input logic [31:0] exm_data,
    input logic        mwb_we,
    input logic [4:0]  mwb_addr,
    input logic [31:0] mwb_data
  );
    if (addr == 5'd0)                       return 32'd0;
    else if (exm_we && (exm_addr == addr))  return exm_data;
    else if (mwb_we && (mwb_addr == addr))  return mwb_data;
    else                                    return rf_data;
  endfunction

  always_comb begin
    w_op_a = fwd_sel(bus.IdRsAddr, bus.RegARdData, bus.ExMemRegWrite, bus.ExMemWrAddr,
                     bus.ExMemWrData, bus.MemWbRegWrite, bus.MemWbWrAddr, bus.MemWbWrData);
    w_op_b = fwd_sel(bus.IdRtAddr, bus.RegBRdData, bus.ExMemRegWrite, bus.ExMemWrAddr,
                     bus.ExMemWrData, bus.MemWbRegWrite, bus.MemWbWrAddr, bus.MemWbWrData);
  end

  assign w_hazard = r_ex_valid && r_ex_mem_read && (r_ex_rt_addr != 5'd0) && bus.IdValid &&
                    ((r_ex_rt_addr == bus.IdRsAddr) || (r_ex_rt_addr == bus.IdRtAddr));
  // HOLD masks the hazard so a single load never costs more than one bubble.
  assign w_stall  = w_hazard && !bus.Flush && (r_state == RUN);
  assign w_bubble = bus.Flush || w_stall;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= RUN;
    end else if (bus.Flush) begin
      r_state <= RUN;
    end else if (w_stall) begin
      r_state <= HOLD;
    end else begin
      r_state <= RUN;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_rt_addr   <= '0;
      r_ex_rd_addr   <= '0;
      r_ex_imm       <= '0;
      r_ex_ctrl      <= '0;
      r_ex_mem_read  <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else if (w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_rt_addr   <= '0;
      r_ex_rd_addr   <= '0;
      r_ex_imm       <= '0;
      r_ex_ctrl      <= '0;
      r_ex_mem_read  <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else begin
      r_ex_valid     <= bus.IdValid;
      r_ex_rs_data   <= w_op_a;
      r_ex_rt_data   <= w_op_b;
      r_ex_rt_addr   <= bus.IdRtAddr;
      r_ex_rd_addr   <= bus.IdRdAddr;
      r_ex_imm       <= bus.IdImm;
      r_ex_ctrl      <= bus.IdValid ? bus.IdCtrl : '0;
      r_ex_mem_read  <= bus.IdValid && bus.IdMemRead;
      r_ex_reg_write <= bus.IdValid && bus.IdRegWrite;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bus.Stall       = w_stall;
  assign bus.ExValid     = r_ex_valid;
  assign bus.ExRsData    = r_ex_rs_data;
  assign bus.ExRtData    = r_ex_rt_data;
  assign bus.ExRtAddr    = r_ex_rt_addr;
  assign bus.ExRdAddr    = r_ex_rd_addr;
  assign bus.ExImm       = r_ex_imm;
  assign bus.ExCtrl      = r_ex_ctrl;
  assign bus.ExMemRead   = r_ex_mem_read;
  assign bus.ExRegWrite  = r_ex_reg_write;
  assign bus.BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass priority, zero register, load-use bubble,
// flush priority, async reset during HOLD and bubble-counter saturation (CNT_W=4).
module tb_id_ex_stage;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   failures;

  id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.IdValid = 0; bus.IdRsAddr = 0; bus.IdRtAddr = 0; bus.IdRdAddr = 0;
    bus.IdImm = 0; bus.IdCtrl = 0; bus.IdMemRead = 0; bus.IdRegWrite = 0;
    bus.RegARdData = 0; bus.RegBRdData = 0;
    bus.ExMemWrAddr = 0; bus.ExMemWrData = 0; bus.ExMemRegWrite = 0;
    bus.MemWbWrAddr = 0; bus.MemWbWrData = 0; bus.MemWbRegWrite = 0;
    bus.Flush = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    Rst_n = 1'b1;
    #2 Rst_n = 1'b0;
    #1;
    check_eq("rst_exvalid", bus.ExValid, 0);
    check_eq("rst_count", bus.BubbleCount, 0);
    check_eq("rst_ctrl", bus.ExCtrl, 0);
    step(); step();
    Rst_n = 1'b1;

    // Bypass priority on operand A
    bus.IdValid = 1; bus.IdRsAddr = 5; bus.RegARdData = 32'h1111;
    bus.ExMemWrAddr = 5; bus.ExMemWrData = 32'hAAAA0000; bus.ExMemRegWrite = 1;
    bus.MemWbWrAddr = 5; bus.MemWbWrData = 32'h5555; bus.MemWbRegWrite = 1;
    step();
    check_eq("fwd_exmem_wins", bus.ExRsData, 32'hAAAA0000);
    check_eq("fwd_valid", bus.ExValid, 1);
    bus.ExMemRegWrite = 0;
    step();
    check_eq("fwd_memwb", bus.ExRsData, 32'h00005555);
    bus.MemWbRegWrite = 0;
    step();
    check_eq("fwd_regfile", bus.ExRsData, 32'h1111);

    // Zero register on B plus field passthrough
    bus.IdRtAddr = 0; bus.RegBRdData = 32'h1234;
    bus.ExMemWrAddr = 0; bus.ExMemWrData = 32'hFFFFFFFF; bus.ExMemRegWrite = 1;
    bus.MemWbWrAddr = 0; bus.MemWbWrData = 32'hFFFFFFFF; bus.MemWbRegWrite = 1;
    bus.IdImm = 32'hDEADBEEF; bus.IdCtrl = 12'hABC; bus.IdRdAddr = 9; bus.IdRegWrite = 1;
    step();
    check_eq("zero_reg_b", bus.ExRtData, 0);
    check_eq("imm_pass", bus.ExImm, 32'hDEADBEEF);
    check_eq("ctrl_pass", bus.ExCtrl, 12'hABC);
    check_eq("rd_pass", bus.ExRdAddr, 9);
    check_eq("regwr_pass", bus.ExRegWrite, 1);
    bus.IdRtAddr = 7; bus.ExMemRegWrite = 0; bus.MemWbWrAddr = 7; bus.MemWbWrData = 32'hCAFE;
    step();
    check_eq("fwd_b_memwb", bus.ExRtData, 32'hCAFE);

    // Invalid instruction: control cleared, data still captured
    bus.IdValid = 0; bus.IdMemRead = 1;
    step();
    check_eq("inv_valid", bus.ExValid, 0);
    check_eq("inv_ctrl", bus.ExCtrl, 0);
    check_eq("inv_memread", bus.ExMemRead, 0);
    check_eq("inv_regwr", bus.ExRegWrite, 0);
    check_eq("inv_rd", bus.ExRdAddr, 9);

    // Load-use hazard
    clear_inputs();
    bus.IdValid = 1; bus.IdMemRead = 1; bus.IdRegWrite = 1; bus.IdRsAddr = 1; bus.IdRtAddr = 8;
    #1 check_eq("lu_nostall_pre", bus.Stall, 0);
    step();
    check_eq("lu_load_in_ex", bus.ExMemRead, 1);
    bus.IdMemRead = 0; bus.IdRsAddr = 8; bus.IdRtAddr = 2;
    #1 check_eq("lu_stall", bus.Stall, 1);
    step();
    check_eq("lu_bubble_valid", bus.ExValid, 0);
    check_eq("lu_count1", bus.BubbleCount, 1);
    check_eq("lu_hold_nostall", bus.Stall, 0);
    step();
    check_eq("lu_enter_valid", bus.ExValid, 1);
    check_eq("lu_enter_rt", bus.ExRtAddr, 2);
    check_eq("lu_count_still1", bus.BubbleCount, 1);

    // Flush and hazard together
    bus.IdMemRead = 1; bus.IdRsAddr = 1; bus.IdRtAddr = 8;
    step();
    bus.IdMemRead = 0; bus.IdRsAddr = 8; bus.Flush = 1;
    #1 check_eq("fl_stall0", bus.Stall, 0);
    step();
    bus.Flush = 0;
    check_eq("fl_valid0", bus.ExValid, 0);
    check_eq("fl_count2", bus.BubbleCount, 2);
    step();
    check_eq("fl_run_valid", bus.ExValid, 1);

    // Async reset while in HOLD
    bus.IdMemRead = 1; bus.IdRsAddr = 1; bus.IdRtAddr = 8;
    step();
    bus.IdMemRead = 0; bus.IdRsAddr = 8;
    step();
    check_eq("ar_pre_count", bus.BubbleCount, 3);
    #1 Rst_n = 1'b0;
    #1;
    check_eq("ar_count0", bus.BubbleCount, 0);
    check_eq("ar_valid0", bus.ExValid, 0);
    check_eq("ar_rt0", bus.ExRtAddr, 0);
    check_eq("ar_rs0", bus.ExRsData, 0);
    step();
    Rst_n = 1'b1;
    #1 check_eq("ar_stall0", bus.Stall, 0);
    step();
    check_eq("ar_run_valid", bus.ExValid, 1);

    // Counter saturation
    bus.Flush = 1;
    for (int i = 0; i < 14; i++) step();
    check_eq("sat_14", bus.BubbleCount, 14);
    for (int i = 0; i < 6; i++) step();
    check_eq("sat_20", bus.BubbleCount, 15);
    check_eq("sat_valid", bus.ExValid, 0);
    step();
    check_eq("sat_hold", bus.BubbleCount, 15);
    bus.Flush = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
